// File: rtl/alu_seq_core.sv
// Sequential ALU execute stage: ADD, SUB (a + b_neg) and iterative shift-add unsigned MUL.
// Latency: done rises 2 edges after the accepting edge (ADD/SUB/reserved), WIDTH+1 for MUL.
// Backpressure: none; start is only sampled in IDLE, requests arriving while busy are dropped.
module alu_seq_core #(
    parameter int WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH:0]     b_neg,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               zero,
    output logic               neg,
    output logic               err
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       op_lat;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic [WIDTH:0]   bn_lat;
    logic [RW-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic             err_pend;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] b_sh;
    logic [RW-1:0]    partial;
    logic [RW-1:0]    exec_val;
    logic             exec_err;

    assign sum_w   = {1'b0, a_lat} + {1'b0, b_lat};
    assign diff_w  = {1'b0, a_lat} + bn_lat;
    assign b_sh    = b_lat >> cnt;
    assign partial = b_sh[0] ? (RW'(a_lat) << cnt) : '0;

    // Value written into acc on each EXEC cycle; MUL accumulates one partial product per cycle.
    always_comb begin
        exec_val = '0;
        exec_err = 1'b0;
        case (op_lat)
            OP_ADD:  exec_val = RW'(sum_w);
            OP_SUB:  exec_val = RW'($signed(diff_w));
            OP_MUL:  exec_val = acc + partial;
            default: exec_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_lat   <= '0;
            a_lat    <= '0;
            b_lat    <= '0;
            bn_lat   <= '0;
            acc      <= '0;
            cnt      <= '0;
            err_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b1;
            neg      <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_lat <= op;
                        a_lat  <= a;
                        b_lat  <= b;
                        bn_lat <= b_neg;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    acc      <= exec_val;
                    err_pend <= exec_err;
                    if (op_lat != OP_MUL || cnt == CNT_LAST) begin
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // Outputs are published only here so they stay stable between done pulses.
                    result <= acc;
                    zero   <= (acc == '0);
                    neg    <= (op_lat == OP_SUB) & acc[RW-1];
                    err    <= err_pend;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core: table of vectors plus random ops checked through a scoreboard queue,
// followed by continuous-start, reserved-op and reset-abort sequences.
module tb_alu_seq_core;

    localparam int W  = 3;
    localparam int RW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W:0]    b_neg;
    logic          busy;
    logic          done;
    logic [RW-1:0] result;
    logic          zero;
    logic          neg;
    logic          err;

    always #5 clk = ~clk;

    alu_seq_core #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .b_neg  (b_neg),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero),
        .neg    (neg),
        .err    (err)
    );

    typedef struct {
        logic [1:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [RW-1:0] r;
        logic          z;
        logic          n;
        logic          e;
        int            lat;
    } vec_t;

    typedef struct {
        logic [RW-1:0] r;
        logic          z;
        logic          n;
        logic          e;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 with no request pending at %0t", $time);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_result", 32'(result), 32'(mon_e.r));
                chk("sb_zero",   32'(zero),   32'(mon_e.z));
                chk("sb_neg",    32'(neg),    32'(mon_e.n));
                chk("sb_err",    32'(err),    32'(mon_e.e));
            end
        end
    end

    function automatic logic [W:0] negate(input logic [W-1:0] v);
        logic [W:0] t;
        t = {1'b0, v};
        return ~t + 1'b1;
    endfunction

    // Independent reference using native arithmetic rather than shift-add.
    function automatic vec_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        vec_t v;
        logic signed [31:0] d;
        v.op = o; v.a = x; v.b = y; v.e = 1'b0; v.n = 1'b0; v.lat = 2;
        case (o)
            2'b00: v.r = RW'(int'(x) + int'(y));
            2'b01: begin
                d   = int'(x) - int'(y);
                v.r = d[RW-1:0];
                v.n = d < 0;
            end
            2'b10: begin
                v.r   = RW'(int'(x) * int'(y));
                v.lat = W + 1;
            end
            default: begin
                v.r = '0;
                v.e = 1'b1;
            end
        endcase
        v.z = (v.r == '0);
        return v;
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        exp_t e;
        int   k;
        @(negedge clk);
        op = v.op; a = v.a; b = v.b; b_neg = negate(v.b); start = 1'b1;
        e.r = v.r; e.z = v.z; e.n = v.n; e.e = v.e;
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom); a = W'($urandom); b = W'($urandom); b_neg = (W+1)'($urandom);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        k = 0;
        while (done !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (k >= 30) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no done within 30 cycles, required latency %0d", tag, v.lat);
        end else begin
            chk({tag, "_latency"}, 32'(k), 32'(v.lat));
            chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        end
    endtask

    vec_t tbl[13];
    vec_t rv;
    int   dn_edges[$];

    initial begin
        tbl[0]  = '{2'b00, 3'd5, 3'd7, 6'd12,      1'b0, 1'b0, 1'b0, 2};
        tbl[1]  = '{2'b00, 3'd0, 3'd0, 6'd0,       1'b1, 1'b0, 1'b0, 2};
        tbl[2]  = '{2'b00, 3'd7, 3'd7, 6'd14,      1'b0, 1'b0, 1'b0, 2};
        tbl[3]  = '{2'b01, 3'd2, 3'd7, 6'b111011,  1'b0, 1'b1, 1'b0, 2};
        tbl[4]  = '{2'b01, 3'd3, 3'd3, 6'd0,       1'b1, 1'b0, 1'b0, 2};
        tbl[5]  = '{2'b01, 3'd0, 3'd0, 6'd0,       1'b1, 1'b0, 1'b0, 2};
        tbl[6]  = '{2'b01, 3'd0, 3'd7, 6'b111001,  1'b0, 1'b1, 1'b0, 2};
        tbl[7]  = '{2'b01, 3'd7, 3'd0, 6'd7,       1'b0, 1'b0, 1'b0, 2};
        tbl[8]  = '{2'b10, 3'd7, 3'd7, 6'b110001,  1'b0, 1'b0, 1'b0, 4};
        tbl[9]  = '{2'b10, 3'd6, 3'd0, 6'd0,       1'b1, 1'b0, 1'b0, 4};
        tbl[10] = '{2'b10, 3'd5, 3'd3, 6'd15,      1'b0, 1'b0, 1'b0, 4};
        tbl[11] = '{2'b11, 3'd5, 3'd5, 6'd0,       1'b1, 1'b0, 1'b1, 2};
        tbl[12] = '{2'b10, 3'd1, 3'd6, 6'd6,       1'b0, 1'b0, 1'b0, 4};

        // Reset with start asserted: nothing may be accepted.
        rst_n = 1'b0; start = 1'b1; op = 2'b00; a = 3'd1; b = 3'd1; b_neg = negate(3'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_zero",   32'(zero),   32'd1);
        chk("rst_neg",    32'(neg),    32'd0);
        chk("rst_err",    32'(err),    32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 13; i++) run_op(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 12; i++) begin
            rv = model(2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
            run_op(rv, $sformatf("rnd%0d", i));
        end

        // start held high: accepts at edges 0, 3, 6 so done appears at edges 2, 5, 8.
        @(negedge clk);
        rv = model(2'b00, 3'd1, 3'd2);
        for (int i = 0; i < 3; i++) sbq.push_back('{rv.r, rv.z, rv.n, rv.e});
        op = 2'b00; a = 3'd1; b = 3'd2; b_neg = negate(3'd2); start = 1'b1;
        for (int ed = 0; ed < 9; ed++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) dn_edges.push_back(ed);
        end
        start = 1'b0;
        chk("cont_done_count", 32'(dn_edges.size()), 32'd3);
        if (dn_edges.size() == 3) begin
            chk("cont_done_edge0", 32'(dn_edges[0]), 32'd2);
            chk("cont_done_edge1", 32'(dn_edges[1]), 32'd5);
            chk("cont_done_edge2", 32'(dn_edges[2]), 32'd8);
        end

        // Leave err set so the abort must visibly clear it.
        run_op(model(2'b11, 3'd2, 3'd3), "rsv");
        chk("rsv_err_held", 32'(err), 32'd1);

        // Reset asserted over edge 2 of a MUL: the request dies silently.
        @(negedge clk);
        op = 2'b10; a = 3'd7; b = 3'd7; b_neg = negate(3'd7); start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy",   32'(busy),   32'd0);
        chk("abort_done",   32'(done),   32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_zero",   32'(zero),   32'd1);
        chk("abort_neg",    32'(neg),    32'd0);
        chk("abort_err",    32'(err),    32'd0);
        repeat (8) @(negedge clk);
        chk("abort_busy_later", 32'(busy), 32'd0);

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
